imm_gen_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle immediate generator, used in the pipelined RISC-V core's decode stage.
- Accepts a 32-bit instruction through a valid/ready handshake and classifies its immediate type.
- Produces a sign-extended XLEN-bit immediate (RV32I/RV64I), plus type, illegal flag and a pass-through tag, after DEPTH register stages with full backpressure.

---
 rtl/imm_gen_pkg.sv | 35 +++
 rtl/imm_decode.sv | 78 +++++++
 rtl/imm_gen_pipe.sv | 135 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined RISC-V immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmI    = 3'd1,
    ImmS    = 3'd2,
    ImmB    = 3'd3,
    ImmU    = 3'd4,
    ImmJ    = 3'd5
  } imm_type_e;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // Counter slots 0..5 follow imm_type_e; slot 6 counts illegal entries.
  localparam int unsigned NumStatCnt     = 7;
  localparam int unsigned StatIllegalIdx = 6;

  // funct3 values 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount, not an immediate.
  function automatic logic is_shift_f3(logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: classifies the opcode and builds the XLEN-wide immediate.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       imm_type_o,
  output logic            illegal_o
);

  localparam bit Rv64 = (XLEN == 64);

  logic [31:0] imm32;
  logic        use_shamt;
  logic [5:0]  shamt;
  logic        shift_op;

  assign shift_op = is_shift_f3(instr_i[14:12]);

  always_comb begin
    imm32      = '0;
    use_shamt  = 1'b0;
    shamt      = {(Rv64 ? instr_i[25] : 1'b0), instr_i[24:20]};
    imm_type_o = ImmNone;
    illegal_o  = 1'b0;
    case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm_type_o = ImmU;
        imm32      = {instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        imm_type_o = ImmJ;
        imm32      = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      OPC_BRANCH: begin
        imm_type_o = ImmB;
        imm32      = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OPC_STORE: begin
        imm_type_o = ImmS;
        imm32      = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_JALR, OPC_LOAD, OPC_SYSTEM: begin
        imm_type_o = ImmI;
        imm32      = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_OPIMM: begin
        imm_type_o = ImmI;
        use_shamt  = shift_op;
        imm32      = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_OPIMM32: begin
        if (Rv64) begin
          imm_type_o = ImmI;
          use_shamt  = shift_op;
          shamt      = {1'b0, instr_i[24:20]};
          imm32      = {{20{instr_i[31]}}, instr_i[31:20]};
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_OP: begin
        imm_type_o = ImmNone;
      end
      OPC_OP32: begin
        illegal_o = !Rv64;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  assign imm_o = use_shamt ? XLEN'(shamt) : XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// DEPTH-stage valid/ready pipeline around imm_decode with flush and full backpressure.
// Optional per-type handshake counters are built when IMM_GEN_STATS_EN is defined.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_type_e        out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_STATS_EN
  ,
  input  logic [2:0]       stat_sel,
  output logic [31:0]      stat_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        imm_type;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic            dec_illegal;
  stage_t          dec;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .imm_type_o(dec_type),
    .illegal_o (dec_illegal)
  );

  assign dec = '{imm: dec_imm, imm_type: dec_type, illegal: dec_illegal, tag: in_tag};

  logic [DEPTH-1:0] valid_q;
  stage_t           data_q [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] prev_valid;
  stage_t           prev_data [DEPTH];

  // Advance enables ripple back from the consumer so a full pipe still streams 1/cycle.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = !valid_q[DEPTH-1] || out_ready;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end
  end

  always_comb begin
    prev_valid    = '0;
    prev_valid[0] = in_valid;
    prev_data[0]  = dec;
    for (int k = 1; k < int'(DEPTH); k++) begin
      prev_valid[k] = valid_q[k-1];
      prev_data[k]  = data_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (flush) begin
          valid_q[k] <= 1'b0;
        end else if (adv[k]) begin
          valid_q[k] <= prev_valid[k];
        end
        // Payload only moves with a valid entry so a stalled or empty stage keeps its value.
        if (adv[k] && prev_valid[k]) begin
          data_q[k] <= prev_data[k];
        end
      end
    end
  end

  assign in_ready    = adv[0];
  assign out_valid   = valid_q[DEPTH-1];
  assign out_imm     = data_q[DEPTH-1].imm;
  assign out_type    = data_q[DEPTH-1].imm_type;
  assign out_illegal = data_q[DEPTH-1].illegal;
  assign out_tag     = data_q[DEPTH-1].tag;

`ifdef IMM_GEN_STATS_EN
  logic [31:0] cnt_q [NumStatCnt];
  logic        out_hs;

  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumStatCnt); i++) begin
        cnt_q[i] <= '0;
      end
    end else if (out_hs) begin
      if (cnt_q[out_type] != 32'hFFFF_FFFF) begin
        cnt_q[out_type] <= cnt_q[out_type] + 32'd1;
      end
      if (out_illegal && (cnt_q[StatIllegalIdx] != 32'hFFFF_FFFF)) begin
        cnt_q[StatIllegalIdx] <= cnt_q[StatIllegalIdx] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    if (int'(stat_sel) < int'(NumStatCnt)) begin
      stat_cnt = cnt_q[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: RV32 and RV64 instances share one stimulus stream and are checked
// against an arithmetic reference decoder.
module tb_imm_gen_pipe;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;
  logic             in_ready32, in_ready64;
  logic             out_valid32, out_valid64;
  logic [31:0]      out_imm32;
  logic [63:0]      out_imm64;
  logic [2:0]       out_type32, out_type64;
  logic             out_ill32, out_ill64;
  logic [TAG_W-1:0] out_tag32, out_tag64;
`ifdef IMM_GEN_STATS_EN
  logic [2:0]       stat_sel;
  logic [31:0]      stat_cnt32, stat_cnt64;
  logic [31:0]      cnt_m32 [8];
  logic [31:0]      cnt_m64 [8];
`endif

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_type(out_type32), .out_illegal(out_ill32), .out_tag(out_tag32)
`ifdef IMM_GEN_STATS_EN
    , .stat_sel(stat_sel), .stat_cnt(stat_cnt32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_type(out_type64), .out_illegal(out_ill64), .out_tag(out_tag64)
`ifdef IMM_GEN_STATS_EN
    , .stat_sel(stat_sel), .stat_cnt(stat_cnt64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]      imm32;
    logic [63:0]      imm64;
    logic [2:0]       t32, t64;
    bit               i32, i64;
    logic [TAG_W-1:0] tag;
    int               cyc;
    bit               strict;
  } exp_t;

  exp_t             sb [$];
  int               checks = 0;
  int               failures = 0;
  bit               strict_lat = 1'b0;
  logic [TAG_W-1:0] tag_ctr = '0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference decode from the ISA field layouts using signed arithmetic on the whole word.
  function automatic void ref_decode(input logic [31:0] ins, input bit rv64,
                                     output logic [63:0] imm, output logic [2:0] typ,
                                     output bit ill);
    longint s;
    bit     sh;
    s   = longint'($signed(ins));
    sh  = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
    imm = '0; typ = 3'd0; ill = 1'b0;
    case (ins[6:0])
      7'h37, 7'h17: begin typ = 3'd4; imm = 64'(s) & ~64'hFFF; end
      7'h6F: begin
        typ = 3'd5;
        imm = 64'((s >>> 31) << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
            | (64'(ins[30:21]) << 1);
      end
      7'h63: begin
        typ = 3'd3;
        imm = 64'((s >>> 31) << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
            | (64'(ins[11:8]) << 1);
      end
      7'h23: begin typ = 3'd2; imm = 64'((s >>> 25) << 5) | 64'(ins[11:7]); end
      7'h67, 7'h03, 7'h73: begin typ = 3'd1; imm = 64'(s >>> 20); end
      7'h13: begin
        typ = 3'd1;
        if (sh) imm = rv64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
        else imm = 64'(s >>> 20);
      end
      7'h1B: begin
        if (!rv64) ill = 1'b1;
        else begin
          typ = 3'd1;
          imm = sh ? 64'(ins[24:20]) : 64'(s >>> 20);
        end
      end
      7'h33: ;
      7'h3B: ill = !rv64;
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic void push_exp(input logic [31:0] ins, input logic [TAG_W-1:0] tag,
                                   input int c);
    exp_t        e;
    logic [63:0] imm;
    ref_decode(ins, 1'b0, imm, e.t32, e.i32);
    e.imm32 = imm[31:0];
    ref_decode(ins, 1'b1, e.imm64, e.t64, e.i64);
    e.tag    = tag;
    e.cyc    = c;
    e.strict = strict_lat;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [13];
    logic [31:0] w;
    int          sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B,
            7'h73, 7'h13};
    w   = $urandom;
    sel = $urandom_range(0, 15);
    if (sel < 13) w[6:0] = ops[sel];
    return w;
  endfunction

  task automatic chk_reset(string tag);
    chk({tag, "_valid"}, {out_valid32, out_valid64}, 2'b00);
    chk({tag, "_imm32"}, out_imm32, 0);
    chk({tag, "_imm64"}, out_imm64, 0);
    chk({tag, "_type"}, {out_type32, out_type64}, 0);
    chk({tag, "_ill"}, {out_ill32, out_ill64}, 0);
    chk({tag, "_tag"}, {out_tag32, out_tag64}, 0);
  endtask

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic step(input bit v, input logic [31:0] ins, input bit fl, input bit ordy,
                      output bit acc);
    int c;
    in_valid = v; in_instr = ins; in_tag = tag_ctr; flush = fl; out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready32 && !fl && rst_n;
    c   = cyc;
    @(posedge clk);
    if (acc) begin
      push_exp(ins, tag_ctr, c);
      tag_ctr++;
    end
    #1;
  endtask

  // Monitor: pops on output handshake, checks hold-while-stalled and flush emptying.
  bit           held = 1'b0;
  bit           flush_prev = 1'b0;
  logic [127:0] saved;
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst_n) begin
      sb.delete();
      held = 1'b0;
      flush_prev = 1'b0;
`ifdef IMM_GEN_STATS_EN
      for (int i = 0; i < 8; i++) begin cnt_m32[i] = '0; cnt_m64[i] = '0; end
`endif
    end else begin
      chk("in_ready_64_vs_32", in_ready64, in_ready32);
      chk("out_valid_64_vs_32", out_valid64, out_valid32);
      if (flush_prev) chk("valid_after_flush", out_valid32, 1'b0);
      if (held)
        chk("stall_hold", {out_valid32, out_imm32, out_type32, out_ill32, out_tag32,
                           out_imm64, out_type64, out_ill64, out_tag64}, saved);
      if (out_valid32 && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output_tag", out_tag32, 5'h1F ^ out_tag32);
        end else begin
          e   = sb.pop_front();
          lat = cyc - e.cyc;
          chk("imm32", out_imm32, e.imm32);
          chk("type32", out_type32, e.t32);
          chk("ill32", out_ill32, e.i32);
          chk("tag32", out_tag32, e.tag);
          chk("imm64", out_imm64, e.imm64);
          chk("type64", out_type64, e.t64);
          chk("ill64", out_ill64, e.i64);
          chk("tag64", out_tag64, e.tag);
          if (e.strict) chk("latency", lat, DEPTH);
          else chk("latency_min", lat >= int'(DEPTH), 1'b1);
`ifdef IMM_GEN_STATS_EN
          cnt_m32[e.t32]++;
          cnt_m64[e.t64]++;
          if (e.i32) cnt_m32[6]++;
          if (e.i64) cnt_m64[6]++;
`endif
        end
      end
      held  = out_valid32 && !out_ready && !flush;
      saved = {out_valid32, out_imm32, out_type32, out_ill32, out_tag32,
               out_imm64, out_type64, out_ill64, out_tag64};
      if (flush) sb.delete();
      flush_prev = flush;
    end
  end

  logic [31:0] dir_vec [9];
  logic [31:0] bp_vec [4];

  initial begin
    bit acc;
    int idx;
    int budget;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
`ifdef IMM_GEN_STATS_EN
    stat_sel = '0;
`endif
    dir_vec = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h800002B7, 32'h02109093,
                32'h0000001B, 32'h00000000, 32'h002081B3, 32'h0000003B};
    bp_vec  = '{32'h00100093, 32'h00A12023, 32'h123452B7, 32'hFFF08067};
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    // Back-to-back directed stream, exact latency.
    strict_lat = 1'b1;
    foreach (dir_vec[i]) step(1'b1, dir_vec[i], 1'b0, 1'b1, acc);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, acc);
    strict_lat = 1'b0;

    // Backpressure: only DEPTH entries fit while the consumer stalls.
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(idx < 4, (idx < 4) ? bp_vec[idx % 4] : 32'h0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, DEPTH);
    chk("bp_in_ready", in_ready32, 1'b0);
    budget = 0;
    while (idx < 4 && budget < 20) begin
      step(1'b1, bp_vec[idx % 4], 1'b0, 1'b1, acc);
      if (acc) idx++;
      budget++;
    end
    chk("bp_all_accepted", idx, 4);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, acc);

    // Flush with two entries in flight plus a same-cycle input.
    step(1'b1, 32'h00500113, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00600193, 1'b0, 1'b0, acc);
    step(1'b1, 32'h00700213, 1'b1, 1'b0, acc);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, acc);

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) < 7, acc);
    end

    budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      step(1'b0, '0, 1'b0, 1'b1, acc);
      budget++;
    end
    chk("drain_empty", sb.size(), 0);

`ifdef IMM_GEN_STATS_EN
    for (int s = 0; s < 8; s++) begin
      stat_sel = 3'(s);
      #1;
      chk("stat32", stat_cnt32, (s < 7) ? cnt_m32[s] : 32'd0);
      chk("stat64", stat_cnt64, (s < 7) ? cnt_m64[s] : 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
